// File: rtl/pipe_stall_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath and its stall/flush controller.
// The datapath uses the master modport and the controller uses the slave modport.
interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       r1AddrD;
  logic [4:0]       r2AddrD;
  logic [4:0]       rdE;
  logic             memReadE;
  logic             pcSrcE;
  logic             memReqM;
  logic             memReadyM;
  logic             stallF;
  logic             stallD;
  logic             stallE;
  logic             stallM;
  logic             stallW;
  logic             flushD;
  logic             flushE;
  logic             memTimeout;
  logic [CNT_W-1:0] loadStallCnt;

  modport master (
    output r1AddrD, r2AddrD, rdE, memReadE, pcSrcE, memReqM, memReadyM,
    input  stallF, stallD, stallE, stallM, stallW, flushD, flushE,
           memTimeout, loadStallCnt
  );

  modport slave (
    input  r1AddrD, r2AddrD, rdE, memReadE, pcSrcE, memReqM, memReadyM,
    output stallF, stallD, stallE, stallM, stallW, flushD, flushE,
           memTimeout, loadStallCnt
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the RV32 5-stage pipe: handles load-use bubbles, taken-branch
// flushes and whole-pipe freezes on slow data memory, with a sticky watchdog and a stall counter.
module pipe_stall_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic            clk,
  input  logic            rstN,
  pipe_stall_ctrl_if.slave bus
);
  localparam int WC_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {RUN, MEMWAIT, ERR} state_e;

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wait_q, wait_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu, mem_hold, lu_active;

  always_comb begin
    lu = bus.memReadE && (bus.rdE != 5'd0) &&
         ((bus.rdE == bus.r1AddrD) || (bus.rdE == bus.r2AddrD));
    mem_hold = ((state_q == RUN) && bus.memReqM && !bus.memReadyM) ||
               (state_q == MEMWAIT) || (state_q == ERR);
    lu_active = rstN && !mem_hold && !bus.pcSrcE && lu;
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    cnt_d     = lu_active ? cnt_q + CNT_W'(1) : cnt_q;
    case (state_q)
      RUN: begin
        if (bus.memReqM && !bus.memReadyM) begin
          state_d = MEMWAIT;
          wait_d  = WC_W'(1);
        end
      end
      MEMWAIT: begin
        // A ready arriving on the limit cycle still completes cleanly.
        if (bus.memReadyM) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == WC_W'(TIMEOUT_CYCLES)) begin
          state_d   = ERR;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + WC_W'(1);
        end
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  // Held in reset the pipe fills with bubbles; otherwise freeze > branch flush > load-use.
  always_comb begin
    bus.stallF = 1'b0;
    bus.stallD = 1'b0;
    bus.stallE = 1'b0;
    bus.stallM = 1'b0;
    bus.stallW = 1'b0;
    bus.flushD = 1'b0;
    bus.flushE = 1'b0;
    if (!rstN) begin
      bus.flushD = 1'b1;
      bus.flushE = 1'b1;
    end else if (mem_hold) begin
      bus.stallF = 1'b1;
      bus.stallD = 1'b1;
      bus.stallE = 1'b1;
      bus.stallM = 1'b1;
      bus.stallW = 1'b1;
    end else if (bus.pcSrcE) begin
      bus.flushD = 1'b1;
      bus.flushE = 1'b1;
    end else if (lu) begin
      bus.stallF = 1'b1;
      bus.stallD = 1'b1;
      bus.flushE = 1'b1;
    end
  end

  assign bus.memTimeout   = timeout_q;
  assign bus.loadStallCnt = cnt_q;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed-vector bench: the driver pushes hand-computed expectations per cycle, a negedge
// monitor pops and compares them against the controller outputs.
module tb_pipe_stall_ctrl;
  localparam int CNT_W = 32;
  localparam int TO    = 4;

  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_ALL  = 5'b11111;
  localparam logic [4:0] S_LU   = 5'b11000;
  localparam logic [1:0] F_NONE = 2'b00;
  localparam logic [1:0] F_BOTH = 2'b11;
  localparam logic [1:0] F_E    = 2'b01;

  typedef struct packed {
    int unsigned      id;
    logic [4:0]       stall;
    logic [1:0]       flush;
    logic             to;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  int checks = 0;
  int failures = 0;
  int unsigned vid = 0;
  exp_t exp_q[$];

  pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_stall_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic vec(input logic rst, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] rd, input logic mr, input logic pc,
                     input logic req, input logic rdy, input logic [4:0] es,
                     input logic [1:0] ef, input logic eto, input logic [CNT_W-1:0] ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    rstN          = rst;
    bus.r1AddrD   = r1;
    bus.r2AddrD   = r2;
    bus.rdE       = rd;
    bus.memReadE  = mr;
    bus.pcSrcE    = pc;
    bus.memReqM   = req;
    bus.memReadyM = rdy;
    e.id    = vid;
    e.stall = es;
    e.flush = ef;
    e.to    = eto;
    e.cnt   = ecnt;
    exp_q.push_back(e);
    vid++;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [4:0] as;
      logic [1:0] af;
      e  = exp_q.pop_front();
      as = {bus.stallF, bus.stallD, bus.stallE, bus.stallM, bus.stallW};
      af = {bus.flushD, bus.flushE};
      checks++;
      if (as !== e.stall || af !== e.flush || bus.memTimeout !== e.to ||
          bus.loadStallCnt !== e.cnt) begin
        failures++;
        $display("FAIL vec%0d: got stall=%b flush=%b to=%b cnt=%0d, want stall=%b flush=%b to=%b cnt=%0d",
                 e.id, as, af, bus.memTimeout, bus.loadStallCnt,
                 e.stall, e.flush, e.to, e.cnt);
      end
    end
  end

  initial begin
    bus.r1AddrD = '0; bus.r2AddrD = '0; bus.rdE = '0; bus.memReadE = 1'b0;
    bus.pcSrcE = 1'b0; bus.memReqM = 1'b0; bus.memReadyM = 1'b0;
    //   rst r1 r2 rd mr pc rq rdy  stall   flush   to cnt
    vec(0, 0, 0, 0, 0, 0, 0, 0, S_NONE, F_BOTH, 0, 0);  // 0 held in reset
    vec(1, 0, 0, 0, 0, 0, 0, 0, S_NONE, F_NONE, 0, 0);  // 1 idle
    vec(1, 5, 0, 5, 1, 0, 0, 0, S_LU,   F_E,    0, 0);  // 2 load-use rs1
    vec(1, 0, 0, 0, 0, 0, 0, 0, S_NONE, F_NONE, 0, 1);  // 3
    vec(1, 3, 7, 7, 1, 0, 0, 0, S_LU,   F_E,    0, 1);  // 4 load-use rs2
    vec(1, 0, 0, 0, 1, 0, 0, 0, S_NONE, F_NONE, 0, 2);  // 5 rd=0 load
    vec(1, 5, 0, 5, 0, 0, 0, 0, S_NONE, F_NONE, 0, 2);  // 6 match but not a load
    vec(1, 5, 0, 5, 1, 1, 0, 0, S_NONE, F_BOTH, 0, 2);  // 7 branch beats load-use
    vec(1, 0, 0, 0, 0, 0, 0, 0, S_NONE, F_NONE, 0, 2);  // 8
    vec(1, 0, 0, 0, 0, 0, 1, 1, S_NONE, F_NONE, 0, 2);  // 9 zero-wait access
    vec(1, 0, 0, 0, 0, 0, 0, 0, S_NONE, F_NONE, 0, 2);  // 10 still RUN
    vec(1, 0, 0, 0, 0, 0, 1, 0, S_ALL,  F_NONE, 0, 2);  // 11 wait entry
    vec(1, 5, 0, 5, 1, 1, 1, 0, S_ALL,  F_NONE, 0, 2);  // 12 freeze beats branch
    vec(1, 5, 0, 5, 1, 0, 1, 0, S_ALL,  F_NONE, 0, 2);  // 13 lu not counted
    vec(1, 5, 0, 5, 1, 0, 1, 1, S_ALL,  F_NONE, 0, 2);  // 14 ready, last frozen
    vec(1, 5, 0, 5, 1, 0, 0, 0, S_LU,   F_E,    0, 2);  // 15 lu after release
    vec(1, 0, 0, 0, 0, 0, 0, 0, S_NONE, F_NONE, 0, 3);  // 16
    vec(1, 0, 0, 0, 0, 0, 1, 0, S_ALL,  F_NONE, 0, 3);  // 17 entry, wait=1
    vec(1, 0, 0, 0, 0, 0, 1, 0, S_ALL,  F_NONE, 0, 3);  // 18 wait 1->2
    vec(1, 0, 0, 0, 0, 0, 1, 0, S_ALL,  F_NONE, 0, 3);  // 19 wait 2->3
    vec(1, 0, 0, 0, 0, 0, 1, 0, S_ALL,  F_NONE, 0, 3);  // 20 wait 3->4
    vec(1, 0, 0, 0, 0, 0, 1, 1, S_ALL,  F_NONE, 0, 3);  // 21 ready at limit wins
    vec(1, 0, 0, 0, 0, 0, 0, 0, S_NONE, F_NONE, 0, 3);  // 22 back in RUN
    vec(1, 0, 0, 0, 0, 0, 1, 0, S_ALL,  F_NONE, 0, 3);  // 23 entry
    vec(1, 0, 0, 0, 0, 0, 1, 0, S_ALL,  F_NONE, 0, 3);  // 24
    vec(1, 0, 0, 0, 0, 0, 1, 0, S_ALL,  F_NONE, 0, 3);  // 25
    vec(1, 0, 0, 0, 0, 0, 1, 0, S_ALL,  F_NONE, 0, 3);  // 26
    vec(1, 0, 0, 0, 0, 0, 1, 0, S_ALL,  F_NONE, 0, 3);  // 27 limit, no ready -> ERR
    vec(1, 0, 0, 0, 0, 0, 0, 1, S_ALL,  F_NONE, 1, 3);  // 28 ERR sticky
    vec(1, 5, 0, 5, 1, 1, 0, 0, S_ALL,  F_NONE, 1, 3);  // 29 ERR ignores branch
    vec(0, 5, 0, 5, 1, 0, 0, 0, S_NONE, F_BOTH, 0, 0);  // 30 reset clears ERR
    vec(1, 0, 0, 0, 0, 0, 0, 0, S_NONE, F_NONE, 0, 0);  // 31
    vec(1, 5, 0, 5, 1, 0, 0, 0, S_LU,   F_E,    0, 0);  // 32
    vec(1, 0, 0, 0, 0, 0, 1, 0, S_ALL,  F_NONE, 0, 1);  // 33 entry
    vec(1, 0, 0, 0, 0, 0, 1, 0, S_ALL,  F_NONE, 0, 1);  // 34 MEMWAIT
    vec(0, 0, 0, 0, 0, 0, 1, 0, S_NONE, F_BOTH, 0, 0);  // 35 reset mid-wait
    vec(1, 0, 0, 0, 0, 0, 0, 0, S_NONE, F_NONE, 0, 0);  // 36 RUN after release
    vec(1, 0, 0, 0, 0, 0, 1, 1, S_NONE, F_NONE, 0, 0);  // 37 zero-wait from RUN
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Stall/flush controller for the 5-stage RV32 pipeline; the complement of the forwarding logic.
- Covers the hazards forwarding cannot resolve:
  - load-use dependence: stall F/D, bubble E;
  - taken branch/jump: flush D/E;
  - multi-cycle data-memory access: freeze the whole pipe until the memory handshake completes.
- Also carries a memory-wait watchdog and a load-use stall performance counter.

Parameters:
- TIMEOUT_CYCLES, 255: maximum consecutive wait cycles on a data-memory request before the error is raised.
- CNT_W, 32: width of the load-use stall counter.

Ports:
- clk  input  1  clock
- rstN  input  1  asynchronous active-low reset
- r1AddrD  input  5  rs1 of instruction in Decode
- r2AddrD  input  5  rs2 of instruction in Decode
- rdE  input  5  rd of instruction in Execute
- memReadE  input  1  instruction in Execute is a load
- pcSrcE  input  1  branch/jump taken, resolved in Execute
- memReqM  input  1  Memory stage issues a data-memory request this cycle
- memReadyM  input  1  data memory accepts/completes the request
- stallF  output  1  hold PC
- stallD  output  1  hold F/D register
- stallE  output  1  hold D/E register
- stallM  output  1  hold E/M register
- stallW  output  1  hold M/W register
- flushD  output  1  clear F/D register to a bubble
- flushE  output  1  clear D/E register to a bubble
- memTimeout  output  1  sticky watchdog error
- loadStallCnt  output  CNT_W  number of load-use bubbles inserted

Behaviour:
FSM states: RUN, MEMWAIT, ERR. Reset state is RUN.

Reset values:
- memTimeout=0, loadStallCnt=0, internal waitCnt=0.
- While rstN is low, all stall outputs are 0 and flushD=flushE=1, so the pipe fills with bubbles.

Load-use hazard (lu):
- lu = memReadE && rdE!=0 && (rdE==r1AddrD || rdE==r2AddrD).

Memory hold (memHold):
- memHold = (state==RUN && memReqM && !memReadyM) || state==MEMWAIT || state==ERR.

Output priority, per cycle (combinational from state and inputs):
1. memHold: stallF=stallD=stallE=stallM=stallW=1, flushD=flushE=0. Freeze overrides everything; lu and pcSrcE are evaluated again once the pipe releases, because the E instruction is still present then.
2. Otherwise pcSrcE: flushD=1, flushE=1, all stalls 0. The branch wins over lu because the D instruction is discarded anyway.
3. Otherwise lu: stallF=stallD=1, flushE=1, others 0.
4. Otherwise: all outputs 0.

Transitions:
- RUN -> MEMWAIT when memReqM && !memReadyM; waitCnt <= 1.
- RUN with memReqM && memReadyM is a zero-wait access: no freeze, stay in RUN.
- MEMWAIT -> RUN on memReadyM. That cycle is the last frozen cycle; the pipe advances on the next edge. waitCnt <= 0.
- MEMWAIT, !memReadyM: waitCnt++.
  - When waitCnt==TIMEOUT_CYCLES and memReadyM is still 0: -> ERR, memTimeout <= 1.
  - memReadyM arriving in the same cycle that waitCnt reaches TIMEOUT_CYCLES wins: return to RUN, no error.
- ERR: terminal until reset. Pipe stays frozen and memTimeout stays 1.

Stall counter:
- loadStallCnt increments by 1 on each clock edge where priority case 3 is active.
- Wraps modulo 2^CNT_W.
- Does not count while memHold or pcSrcE is active.

Other rules:
- rd==0 never causes a stall.
- memReqM is ignored while in MEMWAIT; the request is held stable by the frozen pipe.
- Asynchronous reset asserted mid-MEMWAIT returns to RUN immediately and clears waitCnt; the counter is also cleared.

Test Plan:
- Load-use: memReadE=1, rdE=5, r1AddrD=5, no memory activity -> one cycle with stallF=stallD=flushE=1; loadStallCnt 0->1. Repeat with rdE=0 -> no stall, count unchanged.
- Branch vs load-use: pcSrcE=1 together with lu true -> flushD=flushE=1, stallF=0, loadStallCnt unchanged.
- Memory wait: memReqM=1, memReadyM low for 3 cycles then high -> all five stalls high for 4 cycles (entry + 2 MEMWAIT + ready cycle), then 0; lu asserted during the wait is not counted until release.
- Zero-wait access: memReqM=1, memReadyM=1 in the same cycle -> no stall, state stays RUN.
- Watchdog: TIMEOUT_CYCLES=4, memReadyM held low -> memTimeout rises after 4 MEMWAIT cycles and stays high with the pipe frozen. Variant with memReadyM rising on the 4th MEMWAIT cycle -> no error, returns to RUN.
- Reset mid-wait: drop rstN during MEMWAIT -> stalls 0, flushD=flushE=1, memTimeout=0, loadStallCnt=0; after release the FSM is in RUN.
